// File: rtl/nat_join_4.sv
// rtl/nat_join_4.sv - four-way drive/free token join with overrun and skew checking
module nat_join_4 #(
    parameter int unsigned FREE_DLY = 2,
    parameter int unsigned SKEW_MAX = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_drive0,
    input  logic       i_drive1,
    input  logic       i_drive2,
    input  logic       i_drive3,
    input  logic       i_freeNext,
    output logic       o_driveNext,
    output logic       o_free0,
    output logic       o_free1,
    output logic       o_free2,
    output logic       o_free3,
    output logic [3:0] o_pending,
    output logic       o_err
);

    typedef enum logic [2:0] {
        COLLECT   = 3'd0,
        FIRE      = 3'd1,
        WAIT_FREE = 3'd2,
        DELAY     = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    localparam logic [3:0]  DLY     = 4'(FREE_DLY);
    localparam logic [15:0] SKEW    = 16'(SKEW_MAX);
    localparam logic        SKEW_EN = (SKEW_MAX != 0);

    state_t      state;
    state_t      stateNext;
    logic [3:0]  drive;
    logic [3:0]  pend;
    logic [3:0]  dlyCnt;
    logic [15:0] skewCnt;
    logic        err;
    logic        allIn;
    logic        overrun;
    logic        badDrive;
    logic        badFree;
    logic        skewRun;
    logic        skewHit;

    assign drive = {i_drive3, i_drive2, i_drive1, i_drive0};

    // The completing arrival is seen combinationally so a same-cycle full set fires at once.
    assign allIn    = (state == COLLECT) && ((pend | drive) == 4'hF);
    assign overrun  = (state == COLLECT) && ((drive & pend) != 4'h0);
    assign badDrive = (state != COLLECT) && (drive != 4'h0);
    assign badFree  = (state != WAIT_FREE) && i_freeNext;
    assign skewRun  = (state == COLLECT) && (pend != 4'h0) && !allIn;
    assign skewHit  = SKEW_EN && skewRun && (skewCnt != 16'hFFFF) && ((skewCnt + 16'd1) == SKEW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            COLLECT:   if (allIn) stateNext = FIRE;
            FIRE:      stateNext = WAIT_FREE;
            WAIT_FREE: if (i_freeNext) stateNext = (DLY == 4'd0) ? RELEASE : DELAY;
            DELAY:     if (dlyCnt == 4'd1) stateNext = RELEASE;
            RELEASE:   stateNext = COLLECT;
            default:   stateNext = COLLECT;
        endcase
    end

    // pend is dropped at the completing edge so o_pending already reads 0 during FIRE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend    <= 4'h0;
            dlyCnt  <= 4'd0;
            skewCnt <= 16'd0;
            err     <= 1'b0;
        end else begin
            if (allIn) begin
                pend <= 4'h0;
            end else if (state == COLLECT) begin
                pend <= pend | drive;
            end

            if (state == WAIT_FREE && i_freeNext) begin
                dlyCnt <= DLY;
            end else if (state == DELAY) begin
                dlyCnt <= dlyCnt - 4'd1;
            end

            if (allIn) begin
                skewCnt <= 16'd0;
            end else if (skewRun && skewCnt != 16'hFFFF) begin
                skewCnt <= skewCnt + 16'd1;
            end

            err <= err | overrun | badDrive | badFree | skewHit;
        end
    end

    always_comb begin
        o_driveNext = (state == FIRE);
        o_free0     = (state == RELEASE);
        o_free1     = (state == RELEASE);
        o_free2     = (state == RELEASE);
        o_free3     = (state == RELEASE);
        o_pending   = pend;
        o_err       = err;
    end

endmodule
